if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode/control unit.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Drives the IF/ID register (instruction, PC, valid) consumed by decode.
- Honours the decode-stage load-use stall request and decode-resolved jump/branch redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first fetch after reset.
- NOP_INSTR, 32'h0000_0000, value driven on id_instr for a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- stall_i  in  1  hold IF/ID; driven by the decode load-use stall request.
- redirect_valid  in  1  one-cycle pulse: taken jump/branch resolved in decode.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch word address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses arrive in order.
- imem_rdata  in  32  fetched instruction.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC of id_instr.
- id_valid  out  1  id_instr is a real instruction; 0 means bubble.

Behaviour:
- Reset is synchronous on rstn=0:
  - pc_q=RESET_PC; state=REQ; drop=0; skid empty.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0.
  - imem_req=0 during reset.
- State machine:
  - REQ: imem_req=1, imem_addr=pc_q. On imem_gnt: pend_pc<=pc_q, pc_q<=pc_q+4 (32-bit wrap), go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, route the response (see below), then go to REQ if the skid is empty after this cycle, else FULL.
  - FULL: imem_req=0. Go to REQ in the cycle the skid drains.
- Only one request is ever outstanding. imem_req and imem_addr are combinational from state and pc_q. Peak throughput is 1 instruction per 2 cycles.
- Once raised, imem_req/imem_addr are held stable until gnt. A redirect never retracts a pending request.
- Response routing on imem_rvalid in WAIT:
  - drop=1: discard the data, clear drop.
  - stall_i=0 and skid empty: IF/ID <= {rdata, pend_pc, valid=1}.
  - Otherwise: skid <= {rdata, pend_pc}.
- IF/ID update when stall_i=0:
  - skid full: IF/ID <= skid, skid empties. A response in the same cycle then writes the skid. The FSM never lets skid and response overflow.
  - no skid content and no accepted response: IF/ID <= bubble (valid=0, NOP_INSTR, id_pc unchanged).
- When stall_i=1, IF/ID holds all three outputs unchanged.
- Redirect is effective only when redirect_valid=1 and stall_i=0; while stalled it is ignored (decode re-asserts it after the stall). When effective:
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - skid cleared.
  - IF/ID <= bubble, overriding any response or skid transfer this cycle.
  - If state is WAIT and rvalid=0, or state is REQ and gnt=1: drop <= 1.
  - If state is REQ and gnt=0: the pending request keeps its old address; set drop on grant and load the fetch PC from the redirect target. Implement this as a redirect_pending register: the next grant sets drop and the next REQ fetches the target.
  - If state is FULL: go to REQ.
- No architectural branch delay slot: every instruction fetched after the branch is squashed.
- The PC increment ignores low-bit overflow concerns; addresses are always word aligned.
- Reset asserted mid-transaction abandons the outstanding request. The memory model must also be reset.

Decomposition:
- Shared pipeline package/macro file holds:
  - IF state encodings (REQ=0, WAIT=1, FULL=2).
  - NOP_INSTR.
  - RESET_PC default.
- One natural sub-module: if_skid_buf, the 1-entry {instr,pc} holding register with push/pop/clear and a full flag.
- The FSM, PC and IF/ID register stay in if_stage.

Test Plan:
- Reset release, zero-wait memory (gnt same cycle, rvalid next), memory returns addr as data. id_valid pulses every other cycle with id_pc=0,4,8…, id_instr=id_pc, and bubbles between.
- stall_i held 4 cycles while a response for PC 0x10 arrives. IF/ID holds the prior instruction, the skid captures 0x10 and imem_req stays 0. On release id_pc=0x10 the next cycle, then fetch of 0x14 resumes.
- redirect_valid with redirect_pc=0x400 while WAIT on 0x20. The 0x20 response is dropped and never appears on id_valid=1. The next request has imem_addr=0x400, then id_pc=0x400.
- redirect_pc=0x403 while imem_gnt held low 3 cycles in REQ at 0x30. imem_addr stays 0x30 until gnt and that response is dropped. The next request has addr=0x400.
- redirect_valid and stall_i both high in the same cycle. The redirect is ignored, pc_q is unchanged and IF/ID is held.
- rstn=0 asserted in WAIT with data pending. The next cycle id_valid=0, id_instr=0 and imem_req=0. After release the first request is at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types: FSM encodings, IF/ID entry layout, reset constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_stage_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: req/gnt address phase, in-order rvalid data phase.
// Latency: set by the memory; the fetch side keeps at most one request outstanding.
// Backpressure: master holds req/addr stable until gnt; rvalid cannot be stalled.
interface if_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {instr,pc} holding register for a response that cannot enter IF/ID.
// Latency: push visible on dout/full the next cycle.
// Backpressure: none internally; the owner must not push into a full entry without popping.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  fetch_ent_t din,
    output fetch_ent_t dout,
    output logic       full
);

    fetch_ent_t ent;

    // Clear beats push beats pop; push with pop replaces the entry in place.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full <= 1'b0;
            ent  <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            ent  <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    assign dout = ent;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over imem, fills the IF/ID register.
// Latency: grant to IF/ID is one cycle after rvalid; peak one instruction every two cycles.
// Backpressure: stall_i holds IF/ID; an in-flight response parks in a one-entry skid and fetch pauses.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic              id_valid
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;      // PC of the single outstanding request
    logic        drop_q;         // outstanding response belongs to a squashed path
    logic        redir_pend_q;   // redirect arrived while the request was still waiting for gnt
    logic [31:0] redir_tgt_q;

    logic        redir;
    logic [31:0] redir_tgt;
    logic        grant;
    logic        resp;
    logic        resp_use;
    logic        skid_push;
    logic        skid_pop;
    logic        skid_full;
    logic        skid_full_next;
    fetch_ent_t  skid_din;
    fetch_ent_t  skid_dout;

    // A redirect seen during a stall is ignored; decode repeats it afterwards.
    assign redir     = redirect_valid & ~stall_i;
    assign redir_tgt = align_word(redirect_pc);

    assign grant    = (state_q == REQ) & imem.gnt;
    assign resp     = (state_q == WAIT) & imem.rvalid;
    assign resp_use = resp & ~drop_q & ~redir;

    // A usable response goes straight to IF/ID only when IF/ID can take it and nothing older waits.
    assign skid_push      = resp_use & (stall_i | skid_full);
    assign skid_pop       = ~stall_i & skid_full;
    assign skid_full_next = ~redir & (skid_push | (skid_full & ~skid_pop));
    assign skid_din       = '{instr: imem.rdata, pc: pend_pc_q};

    assign imem.req  = rstn & (state_q == REQ);
    assign imem.addr = pc_q;

    if_skid_buf u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (skid_push),
        .pop   (skid_pop),
        .clear (redir),
        .din   (skid_din),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // Next fetch state: resume requesting only once the skid is empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     if (grant) state_d = WAIT;
            WAIT:    if (resp) state_d = skid_full_next ? FULL : REQ;
            FULL:    if (redir || !skid_full_next) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= REQ;
        else       state_q <= state_d;
    end

    // PC, outstanding-request PC, and squash bookkeeping for redirects.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            drop_q       <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= RESET_PC;
        end else if (grant) begin
            pend_pc_q    <= pc_q;
            redir_pend_q <= 1'b0;
            if (redir) begin
                pc_q   <= redir_tgt;
                drop_q <= 1'b1;
            end else if (redir_pend_q) begin
                pc_q   <= redir_tgt_q;
                drop_q <= 1'b1;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end else begin
            // The raised request keeps its address; remember the target for after the grant.
            if (redir && state_q == REQ) begin
                redir_pend_q <= 1'b1;
                redir_tgt_q  <= redir_tgt;
            end else if (redir) begin
                pc_q <= redir_tgt;
            end
            if (resp)                        drop_q <= 1'b0;
            else if (redir && state_q == WAIT) drop_q <= 1'b1;
        end
    end

    // IF/ID register: redirect bubble, hold on stall, else skid, fresh response, or bubble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'h0;
        end else if (redir) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!stall_i) begin
            if (skid_full) begin
                id_valid <= 1'b1;
                id_instr <= skid_dout.instr;
                id_pc    <= skid_dout.pc;
            end else if (resp_use) begin
                id_valid <= 1'b1;
                id_instr <= imem.rdata;
                id_pc    <= pend_pc_q;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order memory that returns the address as data.
// Latency: memory grants same cycle when enabled, rvalid after a programmable delay.
// Backpressure: gnt is withheld via gnt_en to hold the fetch stage in REQ.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;

    logic        gnt_en;
    int          lat;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage_if imem ();

    if_stage dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem.master),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_valid       (id_valid)
    );

    always #5 clk = ~clk;

    // Memory: grant when enabled, answer with the address after lat idle cycles.
    assign imem.gnt    = imem.req & gnt_en;
    assign imem.rvalid = mem_pend & (mem_cnt == 0);
    assign imem.rdata  = mem_addr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= 32'h0;
        end else if (imem.req && imem.gnt) begin
            mem_pend <= 1'b1;
            mem_cnt  <= lat;
            mem_addr <= imem.addr;
        end else if (mem_pend) begin
            if (mem_cnt == 0) mem_pend <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn           = 1'b0;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        gnt_en         = 1'b1;
        lat            = 0;

        // Reset state.
        repeat (3) tick();
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc",    id_pc,    32'h0);
        check("rst_req",   {31'b0, imem.req}, 32'h0);
        rstn = 1'b1;
        #1;
        check("first_req",  {31'b0, imem.req}, 32'h1);
        check("first_addr", imem.addr, 32'h0);

        // Zero-wait streaming: valid every other cycle, PC 0,4,8,C.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zw_bubble", {31'b0, id_valid}, 32'h0);
            check("zw_req_lo", {31'b0, imem.req}, 32'h0);
            tick();
            check("zw_valid", {31'b0, id_valid}, 32'h1);
            check("zw_pc",    id_pc,    32'(4 * i));
            check("zw_instr", id_instr, 32'(4 * i));
            check("zw_addr",  imem.addr, 32'(4 * i + 4));
        end

        // Stall for 4 cycles while the 0x10 response lands in the skid.
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_req",   {31'b0, imem.req}, 32'h0);
            check("stall_valid", {31'b0, id_valid}, 32'h1);
            check("stall_pc",    id_pc, 32'h0000_000C);
        end
        stall_i = 1'b0;
        tick();
        check("unstall_valid", {31'b0, id_valid}, 32'h1);
        check("unstall_pc",    id_pc,    32'h0000_0010);
        check("unstall_instr", id_instr, 32'h0000_0010);
        check("unstall_req",   {31'b0, imem.req}, 32'h1);
        check("unstall_addr",  imem.addr, 32'h0000_0014);
        for (int j = 0; j < 3; j++) begin
            tick();
            tick();
            check("resume_pc", id_pc, 32'(32'h14 + 4 * j));
        end
        check("pre_redir_addr", imem.addr, 32'h0000_0020);

        // Redirect while waiting on 0x20 (response delayed by 2).
        lat = 2;
        tick();
        check("w_req_lo", {31'b0, imem.req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        check("w_redir_bubble", {31'b0, id_valid}, 32'h0);
        tick();
        check("w_drop_wait", {31'b0, id_valid}, 32'h0);
        tick();
        check("w_dropped",   {31'b0, id_valid}, 32'h0);
        check("w_tgt_req",   {31'b0, imem.req}, 32'h1);
        check("w_tgt_addr",  imem.addr, 32'h0000_0400);
        lat = 0;
        tick();
        check("w_tgt_bubble", {31'b0, id_valid}, 32'h0);
        tick();
        check("w_tgt_valid", {31'b0, id_valid}, 32'h1);
        check("w_tgt_pc",    id_pc,    32'h0000_0400);
        check("w_tgt_instr", id_instr, 32'h0000_0400);

        // Redirect to an unaligned target while gnt is withheld in REQ at 0x404.
        gnt_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0403;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            check("g_hold_req",   {31'b0, imem.req}, 32'h1);
            check("g_hold_addr",  imem.addr, 32'h0000_0404);
            check("g_hold_valid", {31'b0, id_valid}, 32'h0);
        end
        gnt_en = 1'b1;
        tick();
        check("g_wait_req",   {31'b0, imem.req}, 32'h0);
        check("g_wait_valid", {31'b0, id_valid}, 32'h0);
        tick();
        check("g_dropped",  {31'b0, id_valid}, 32'h0);
        check("g_tgt_req",  {31'b0, imem.req}, 32'h1);
        check("g_tgt_addr", imem.addr, 32'h0000_0400);
        tick();
        tick();
        check("g_tgt_valid", {31'b0, id_valid}, 32'h1);
        check("g_tgt_pc",    id_pc, 32'h0000_0400);

        // Redirect and stall together: redirect ignored, IF/ID held.
        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        tick();
        redirect_valid = 1'b0;
        stall_i        = 1'b0;
        check("rs_hold_valid", {31'b0, id_valid}, 32'h1);
        check("rs_hold_pc",    id_pc,    32'h0000_0400);
        check("rs_hold_instr", id_instr, 32'h0000_0400);
        tick();
        check("rs_next_valid", {31'b0, id_valid}, 32'h1);
        check("rs_next_pc",    id_pc, 32'h0000_0404);
        check("rs_next_addr",  imem.addr, 32'h0000_0408);

        // Reset while waiting on 0x408 with data pending.
        tick();
        check("r_in_wait", {31'b0, imem.req}, 32'h0);
        rstn = 1'b0;
        tick();
        check("r_valid", {31'b0, id_valid}, 32'h0);
        check("r_instr", id_instr, 32'h0);
        check("r_pc",    id_pc,    32'h0);
        check("r_req",   {31'b0, imem.req}, 32'h0);
        rstn = 1'b1;
        #1;
        check("r_rel_req",  {31'b0, imem.req}, 32'h1);
        check("r_rel_addr", imem.addr, 32'h0);
        tick();
        tick();
        check("r_first_valid", {31'b0, id_valid}, 32'h1);
        check("r_first_pc",    id_pc, 32'h0);

        // Redirect out of FULL: skid content (PC 4) is squashed.
        stall_i = 1'b1;
        tick();
        tick();
        check("f_full_req", {31'b0, imem.req}, 32'h0);
        check("f_full_pc",  id_pc, 32'h0);
        stall_i        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        check("f_redir_valid", {31'b0, id_valid}, 32'h0);
        check("f_redir_req",   {31'b0, imem.req}, 32'h1);
        check("f_redir_addr",  imem.addr, 32'h0000_0200);
        tick();
        check("f_no_skid", {31'b0, id_valid}, 32'h0);
        tick();
        check("f_tgt_valid", {31'b0, id_valid}, 32'h1);
        check("f_tgt_pc",    id_pc, 32'h0000_0200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
